// File: rtl/matrix_key_scanner.sv
// 4x4 active-low key matrix scanner: strobes columns, synchronizes and debounces
// the rows on a slow tick, and reports each confirmed key as row*4+col.
module matrix_key_scanner #(
    parameter int F_CLK          = 50000000,
    parameter int F_SCAN         = 1000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_row,
    output logic [3:0] o_col,
    output logic [3:0] o_key,
    output logic       o_valid,
    output logic       o_pressed
);

    localparam int DIV    = F_CLK / F_SCAN;
    localparam int TICK_W = $clog2(DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_TICKS);

    localparam logic [1:0] SCAN    = 2'd0;
    localparam logic [1:0] CONFIRM = 2'd1;
    localparam logic [1:0] HELD    = 2'd2;

    logic [3:0]        row_p0;
    logic [3:0]        row_s;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [1:0]        state;
    logic [1:0]        col;
    logic [1:0]        row_sel;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              any_active;
    logic              sel_active;
    logic              cnt_done;

    // Lowest active row index wins when several rows are pulled low.
    function automatic logic [1:0] lowest_active(input logic [3:0] rows);
        if (!rows[0])      return 2'd0;
        else if (!rows[1]) return 2'd1;
        else if (!rows[2]) return 2'd2;
        else               return 2'd3;
    endfunction

    function automatic logic [3:0] col_strobe(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    // Stage p0 -> s: two-flop synchronizer, idles high like the pulled-up rows.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            row_p0 <= 4'b1111;
            row_s  <= 4'b1111;
        end else begin
            row_p0 <= i_row;
            row_s  <= row_p0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick       = (tick_cnt == TICK_LAST);
    assign any_active = ~&row_s;
    assign sel_active = ~row_s[row_sel];
    assign cnt_inc    = cnt + 1'b1;
    assign cnt_done   = (cnt_inc == CNT_DONE);

    // Stage tick -> outputs: all state and outputs move only on tick cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= SCAN;
            col       <= 2'd0;
            o_col     <= 4'b1110;
            row_sel   <= 2'd0;
            cnt       <= '0;
            o_key     <= 4'd0;
            o_valid   <= 1'b0;
            o_pressed <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (any_active) begin
                            row_sel <= lowest_active(row_s);
                            cnt     <= '0;
                            state   <= CONFIRM;
                        end else begin
                            col   <= col + 2'd1;
                            o_col <= col_strobe(col + 2'd1);
                        end
                    end
                    CONFIRM: begin
                        if (sel_active) begin
                            if (cnt_done) begin
                                o_key     <= {row_sel, col};
                                o_valid   <= 1'b1;
                                o_pressed <= 1'b1;
                                cnt       <= '0;
                                state     <= HELD;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= SCAN;
                            col   <= col + 2'd1;
                            o_col <= col_strobe(col + 2'd1);
                        end
                    end
                    HELD: begin
                        // Only the latched row matters; any activity restarts the release count.
                        if (!sel_active) begin
                            if (cnt_done) begin
                                o_pressed <= 1'b0;
                                cnt       <= '0;
                                state     <= SCAN;
                                col       <= col + 2'd1;
                                o_col     <= col_strobe(col + 2'd1);
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                    default: begin
                        state <= SCAN;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matrix_key_scanner.sv
// Bench for matrix_key_scanner: a 4x4 key model driven from o_col, table-driven
// press/release records, and hand-built bounce and reset sequences.
module tb_matrix_key_scanner;

    localparam int F_CLK          = 1000;
    localparam int F_SCAN         = 100;
    localparam int DEBOUNCE_TICKS = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        valid;
    logic        pressed;
    logic [15:0] keys;

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  code;
        int          lat;
        logic [3:0]  col_held;
        logic [3:0]  col_after;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    matrix_key_scanner #(
        .F_CLK(F_CLK),
        .F_SCAN(F_SCAN),
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_row(row),
        .o_col(col),
        .o_key(key),
        .o_valid(valid),
        .o_pressed(pressed)
    );

    // Key matrix: a pressed key at (r,c) pulls row r low while column c is strobed.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: o_key=%0d, expected no pulse", key);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("valid_key", {28'd0, key}, {28'd0, mon_exp});
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (pressed !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{16'h0200, 4'd9,  50, 4'b1101, 4'b1011};
        vecs[1] = '{16'h0001, 4'd0,  40, 4'b1110, 4'b1101};
        vecs[2] = '{16'h8000, 4'd15, 70, 4'b0111, 4'b1110};
        vecs[3] = '{16'h8080, 4'd7,  70, 4'b0111, 4'b1110};
        vecs[4] = '{16'h0042, 4'd1,  50, 4'b1101, 4'b1011};
        vecs[5] = '{16'h0110, 4'd4,  40, 4'b1110, 4'b1101};

        keys = 16'h0000;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values and idle column stepping.
        chk("rst_col", col, 4'b1110);
        chk("rst_key", key, 0);
        chk("rst_valid", valid, 0);
        chk("rst_pressed", pressed, 0);
        step(9);  chk("idle_col_n9", col, 4'b1110);
        step(1);  chk("idle_col_n10", col, 4'b1101);
        step(10); chk("idle_col_n20", col, 4'b1011);
        step(10); chk("idle_col_n30", col, 4'b0111);
        step(10); chk("idle_col_n40", col, 4'b1110);

        // Table: press from reset, check latency and columns, release.
        foreach (vecs[i]) begin
            do_reset();
            keys = vecs[i].keys;
            exp_q.push_back(vecs[i].code);
            wait_valid(n);
            chk("press_latency", n, vecs[i].lat);
            chk("pressed_at_valid", pressed, 1);
            chk("col_held", col, vecs[i].col_held);
            step(1);
            chk("valid_width", valid, 0);
            keys = 16'h0000;
            wait_fall(n);
            chk("release_latency", n, 29);
            chk("col_after", col, vecs[i].col_after);
            chk("key_kept", key, vecs[i].code);
        end

        // Press bounce after a clean press/release of key 9.
        do_reset();
        keys = 16'h0200;
        exp_q.push_back(4'd9);
        wait_valid(n);
        chk("clean_press_latency", n, 50);
        step(1);
        keys = 16'h0000;
        wait_fall(n);
        chk("clean_release_latency", n, 29);
        chk("clean_release_col", col, 4'b1011);
        keys = 16'h4000;
        step(20); chk("bounce_col_frozen", col, 4'b1011);
        step(2);  keys = 16'h0000;
        step(8);
        chk("bounce_col_adv", col, 4'b0111);
        chk("bounce_key_kept", key, 9);
        chk("bounce_no_press", pressed, 0);

        // Two keys in column 3, then a bouncing release.
        keys = 16'h8080;
        exp_q.push_back(4'd7);
        wait_valid(n);
        chk("two_key_latency", n, 40);
        keys = 16'h0000;
        step(22); keys = 16'h8080;
        step(10); keys = 16'h0000;
        step(8);  chk("rel_bounce_p40", pressed, 1);
        step(10); chk("rel_bounce_p50", pressed, 1);
        step(9);  chk("rel_bounce_p59", pressed, 1);
        step(1);
        chk("rel_bounce_fall", pressed, 0);
        chk("rel_bounce_col", col, 4'b1110);
        chk("rel_bounce_key", key, 7);

        // Reset while in CONFIRM.
        keys = 16'h0001;
        step(15);
        chk("confirm_col_frozen", col, 4'b1110);
        rst  = 1'b1;
        keys = 16'h0000;
        step(1);
        chk("rst_confirm_col", col, 4'b1110);
        chk("rst_confirm_key", key, 0);
        chk("rst_confirm_valid", valid, 0);
        chk("rst_confirm_pressed", pressed, 0);
        rst = 1'b0;
        step(10);
        chk("restart_scan_col", col, 4'b1101);

        // Reset coinciding with the confirming tick suppresses o_valid.
        keys = 16'h0020;
        step(39);
        chk("confirm2_col_frozen", col, 4'b1101);
        rst  = 1'b1;
        keys = 16'h0000;
        step(1);
        chk("rst_tick_valid", valid, 0);
        chk("rst_tick_pressed", pressed, 0);
        chk("rst_tick_col", col, 4'b1110);
        rst = 1'b0;
        step(20);

        // Reset while in HELD.
        do_reset();
        keys = 16'h1000;
        exp_q.push_back(4'd12);
        wait_valid(n);
        chk("held_press_latency", n, 40);
        step(5);
        chk("held_pressed", pressed, 1);
        rst  = 1'b1;
        keys = 16'h0000;
        step(1);
        chk("rst_held_pressed", pressed, 0);
        chk("rst_held_key", key, 0);
        chk("rst_held_col", col, 4'b1110);
        chk("rst_held_valid", valid, 0);
        rst = 1'b0;
        step(30);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
